// File: rtl/mcl_pkg.sv
// Shared types for the MCL memory-cycle controller: FSM states, latched
// cycle type, and the default NXM timeout.
package mcl_pkg;

  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_PAUSE
  } state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic pse;
    logic fetch;
    logic ar;
    logic arx;
  } cyc_type_t;

  // Words the MBOX will return: one per AR/ARX load on a read, otherwise a
  // single store-done (or completion) transfer.
  function automatic logic [1:0] word_count(input cyc_type_t t);
    return t.rd ? ({1'b0, t.ar} + {1'b0, t.arx}) : 2'd1;
  endfunction

endpackage

// File: rtl/nxm_timer.sv
// Watchdog for MBOX progress: counts while enabled, clears on demand, and
// flags the cycle on which the count reaches TIMEOUT-1.
module nxm_timer
  import mcl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would make update order matter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mbox_cyc_ctl.sv
// EBOX-side sequencer for MBOX memory cycles: latches the request, holds
// EBOX_REQ until ACK, counts returning words and handles pause/abort.
module mbox_cyc_ctl
  import mcl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int VMA_W   = 23
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             MBOX_CYC_REQ,
  input  logic             LOAD_AR,
  input  logic             LOAD_ARX,
  input  logic             VMA_PAUSE,
  input  logic             VMA_WRITE,
  input  logic             VMA_FETCH,
  input  logic [VMA_W-1:0] VMA,
  input  logic             MBOX_ACK,
  input  logic             MB_XFER,
  input  logic             PAGE_FAIL,
  output logic             EBOX_REQ,
  output logic             EBOX_RD,
  output logic             EBOX_WR,
  output logic             EBOX_PSE,
  output logic             EBOX_FETCH,
  output logic [VMA_W-1:0] EBOX_ADDR,
  output logic             EBOX_WAIT,
  output logic             AR_LOAD_EN,
  output logic             ARX_LOAD_EN,
  output logic             PF_HOLD,
  output logic             NXM_ERR,
  output logic             BUSY
);

  state_t           state;
  cyc_type_t        typ;
  cyc_type_t        req_typ;
  logic [VMA_W-1:0] addr;
  logic [1:0]       words_left;
  logic             ebox_req_q;
  logic             busy_q;

  logic st_idle, st_req, st_data, st_pause;
  logic timed;
  logic progress;
  logic tmr_expire;
  logic pf_abort;
  logic nxm_abort;
  logic xfer_take;
  logic last_word;
  logic first_word;

  assign st_idle  = (state == ST_IDLE);
  assign st_req   = (state == ST_REQ);
  assign st_data  = (state == ST_DATA);
  assign st_pause = (state == ST_PAUSE);
  assign timed    = st_req || st_data;

  assign req_typ = '{rd:    LOAD_AR | LOAD_ARX,
                     wr:    VMA_WRITE,
                     pse:   VMA_PAUSE,
                     fetch: VMA_FETCH,
                     ar:    LOAD_AR,
                     arx:   LOAD_ARX};

  // Any ACK in REQ or XFER in DATA counts as MBOX progress and rearms the watchdog.
  assign progress = (st_req && MBOX_ACK) || (st_data && MB_XFER);

  nxm_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_nxm_timer (
    .clk    (clk),
    .rst    (RESET),
    .clr    (!timed || progress),
    .en     (timed),
    .expire (tmr_expire)
  );

  // Strobes are combinational on the causing input; RESET masks them all.
  assign pf_abort   = !RESET && PAGE_FAIL && !st_idle;
  assign nxm_abort  = !RESET && !PAGE_FAIL && tmr_expire && !progress;
  assign xfer_take  = !RESET && !PAGE_FAIL && st_data && MB_XFER;
  assign last_word  = xfer_take && (words_left == 2'd1);
  assign first_word = (words_left == word_count(typ));

  assign AR_LOAD_EN  = xfer_take && typ.rd && typ.ar && first_word;
  assign ARX_LOAD_EN = xfer_take && typ.rd && !(typ.ar && first_word);
  assign PF_HOLD     = pf_abort;
  assign NXM_ERR     = nxm_abort;
  assign EBOX_WAIT   = !RESET && ((MBOX_CYC_REQ && (st_idle || st_pause)) ||
                                  (timed && !last_word));

  assign EBOX_REQ   = ebox_req_q;
  assign BUSY       = busy_q;
  assign EBOX_RD    = typ.rd;
  assign EBOX_WR    = typ.wr;
  assign EBOX_PSE   = typ.pse;
  assign EBOX_FETCH = typ.fetch;
  assign EBOX_ADDR  = addr;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= ST_IDLE;
      typ        <= '0;
      addr       <= '0;
      words_left <= '0;
      ebox_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (MBOX_CYC_REQ) begin
            typ        <= req_typ;
            addr       <= VMA;
            words_left <= word_count(req_typ);
            state      <= ST_REQ;
            ebox_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (pf_abort || nxm_abort) begin
            state      <= ST_IDLE;
            ebox_req_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (MBOX_ACK) begin
            state      <= ST_DATA;
            ebox_req_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (pf_abort || nxm_abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (xfer_take) begin
            words_left <= words_left - 2'd1;
            if (last_word) begin
              if (typ.pse && typ.rd) begin
                state <= ST_PAUSE;
              end else begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (pf_abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (MBOX_CYC_REQ) begin
            // Write half of read-pause-write: keep address and pause context.
            typ.rd     <= 1'b0;
            typ.wr     <= 1'b1;
            typ.ar     <= 1'b0;
            typ.arx    <= 1'b0;
            words_left <= 2'd1;
            state      <= ST_REQ;
            ebox_req_q <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          ebox_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
